// File: rtl/adc_spi_sampler.sv
// Purpose: SPI master that periodically converts a serial ADC word into a parallel sample plus strobe.
// Latency: adc_cs_n low for SCLK_DIV*(2*ADC_BITS+2) cycles; sample/sample_ready update on the cs_n rising edge.
// Backpressure: none; sample_ready is a 1-cycle pulse and conversions start every SAMPLE_INTERVAL cycles.
// Optional: define ADC_DISCARD_FIRST_EN to drop the first conversion after leaving IDLE.
module adc_spi_sampler #(
    parameter int BIT_WIDTH       = 32,
    parameter int ADC_BITS        = 12,
    parameter int SCLK_DIV        = 4,
    parameter int SAMPLE_INTERVAL = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 adc_miso,
    output logic                 adc_sclk,
    output logic                 adc_cs_n,
    output logic [BIT_WIDTH-1:0] sample,
    output logic                 sample_ready,
    output logic                 busy
);

    localparam int DIV_W = $clog2(2 * SCLK_DIV) + 1;
    localparam int BIT_W = $clog2(ADC_BITS) + 1;
    localparam int IVL_W = $clog2(SAMPLE_INTERVAL) + 1;

    localparam logic [DIV_W-1:0] HALF_END = DIV_W'(SCLK_DIV - 1);
    localparam logic [DIV_W-1:0] FULL_END = DIV_W'(2 * SCLK_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(ADC_BITS - 1);
    localparam logic [IVL_W-1:0] IVL_END  = IVL_W'(SAMPLE_INTERVAL - 1);

    // A conversion must fit inside one interval, otherwise restarts would cut it short.
    if (SAMPLE_INTERVAL <= SCLK_DIV * (2 * ADC_BITS + 2)) begin : g_bad_interval
        $error("adc_spi_sampler: SAMPLE_INTERVAL too small for one conversion");
    end
    if (BIT_WIDTH < ADC_BITS) begin : g_bad_width
        $error("adc_spi_sampler: BIT_WIDTH must be >= ADC_BITS");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CS_SETUP,
        S_SHIFT,
        S_CS_HOLD,
        S_WAIT
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [DIV_W-1:0]     div_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [IVL_W-1:0]     ivl_cnt;
    logic [ADC_BITS-1:0]  shreg;
    logic                 start;
    logic                 sclk_rise;
    logic                 sclk_fall;
    logic                 done;
    logic                 keep;

`ifdef ADC_DISCARD_FIRST_EN
    logic discard;

    // Marks the first conversion after IDLE as stale so its result is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            discard <= 1'b0;
        end else if (start && state == S_IDLE) begin
            discard <= 1'b1;
        end else if (done) begin
            discard <= 1'b0;
        end
    end

    assign keep = ~discard;
`else
    assign keep = 1'b1;
`endif

    // Next-state and per-cycle strobes derived from the phase counters.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        sclk_rise = 1'b0;
        sclk_fall = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (enable) begin
                    start     = 1'b1;
                    state_nxt = S_CS_SETUP;
                end
            end
            S_CS_SETUP: begin
                if (div_cnt == HALF_END) state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (div_cnt == HALF_END) sclk_rise = 1'b1;
                if (div_cnt == FULL_END) begin
                    sclk_fall = 1'b1;
                    if (bit_cnt == LAST_BIT) state_nxt = S_CS_HOLD;
                end
            end
            S_CS_HOLD: begin
                if (div_cnt == HALF_END) begin
                    done      = 1'b1;
                    state_nxt = enable ? S_WAIT : S_IDLE;
                end
            end
            S_WAIT: begin
                if (!enable) begin
                    state_nxt = S_IDLE;
                end else if (ivl_cnt == IVL_END) begin
                    start     = 1'b1;
                    state_nxt = S_CS_SETUP;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Counters, shift register and registered SPI/sample outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt      <= '0;
            bit_cnt      <= '0;
            ivl_cnt      <= '0;
            shreg        <= '0;
            adc_sclk     <= 1'b0;
            adc_cs_n     <= 1'b1;
            sample       <= '0;
            sample_ready <= 1'b0;
            busy         <= 1'b0;
        end else begin
            // Half-period counter restarts on every phase change and every sclk period.
            if (state == S_IDLE || state == S_WAIT || state_nxt != state || sclk_fall)
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + 1'b1;

            if (start)          bit_cnt <= '0;
            else if (sclk_fall) bit_cnt <= bit_cnt + 1'b1;

            // Interval counter measures from the cs_n falling edge of each conversion.
            if (start || state == S_IDLE) ivl_cnt <= '0;
            else                          ivl_cnt <= ivl_cnt + 1'b1;

            if (sclk_rise) shreg <= {shreg[ADC_BITS-2:0], adc_miso};

            if (sclk_rise)      adc_sclk <= 1'b1;
            else if (sclk_fall) adc_sclk <= 1'b0;

            if (start)     adc_cs_n <= 1'b0;
            else if (done) adc_cs_n <= 1'b1;

            sample_ready <= done & keep;
            if (done && keep) sample <= BIT_WIDTH'(shreg);

            busy <= done || state_nxt == S_CS_SETUP || state_nxt == S_SHIFT ||
                    state_nxt == S_CS_HOLD;
        end
    end

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Purpose: self-checking bench for adc_spi_sampler with a word-level ADC model and sample scoreboard.
// Latency: expects 52-cycle conversions and 100-cycle pulse spacing at the bench parameters.
// Backpressure: none; the bench only observes sample_ready pulses.
module tb_adc_spi_sampler;

    localparam int BW  = 32;
    localparam int AB  = 12;
    localparam int SD  = 2;
    localparam int SI  = 100;
    localparam int CONV_LEN = SD * (2 * AB + 2);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          adc_miso;
    logic          adc_sclk;
    logic          adc_cs_n;
    logic [BW-1:0] sample;
    logic          sample_ready;
    logic          busy;

    adc_spi_sampler #(
        .BIT_WIDTH(BW), .ADC_BITS(AB), .SCLK_DIV(SD), .SAMPLE_INTERVAL(SI)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .adc_miso(adc_miso),
        .adc_sclk(adc_sclk), .adc_cs_n(adc_cs_n), .sample(sample),
        .sample_ready(sample_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // ADC model: word chosen at cs_n fall, one bit per rising sclk, MSB first.
    logic [11:0] adc_q[$];
    logic [11:0] exp_q[$];
    logic [11:0] cur_word = 12'h0;
    logic [3:0]  rises = 4'd0;
    assign adc_miso = (rises < 4'd12) ? cur_word[4'd11 - rises] : 1'b0;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int low_len = 0;
    int starts = 0;
    int pulses = 0;
    int last_start = -1000;
    int last_pulse = -1;
    int pulse_gap = 0;
    int sclk_idle_err = 0;
    logic prev_cs_n = 1'b1;
    logic prev_sclk = 1'b0;
    logic prev_rdy = 1'b0;

    // Monitor/scoreboard sampled on the falling clock edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            rises = 4'd0;
            low_len = 0;
            last_start = -1000;
        end else begin
            if (!adc_cs_n) begin
                if (prev_cs_n) begin
                    if (adc_q.size() != 0) cur_word = adc_q.pop_front();
                    else                   cur_word = 12'($urandom);
`ifdef ADC_DISCARD_FIRST_EN
                    // A conversion not exactly one interval after the previous one came from idle.
                    if (cyc - last_start == SI) exp_q.push_back(cur_word);
`else
                    exp_q.push_back(cur_word);
`endif
                    last_start = cyc;
                    starts++;
                    rises = 4'd0;
                    low_len = 0;
                end
                low_len++;
                if (adc_sclk && !prev_sclk) rises = rises + 4'd1;
            end else if (adc_sclk) begin
                sclk_idle_err++;
            end
            if (sample_ready) begin
                pulses++;
                check("cs_low_len", low_len, CONV_LEN);
                check("sclk_rises", 32'(rises), AB);
                check("busy_at_rdy", busy, 1'b1);
                check("rdy_width", prev_rdy, 1'b0);
                check("sb_has_entry", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) check("sample_sb", sample, {20'd0, exp_q.pop_front()});
                if (last_pulse >= 0) pulse_gap = cyc - last_pulse;
                last_pulse = cyc;
            end
        end
        prev_cs_n = adc_cs_n;
        prev_sclk = adc_sclk;
        prev_rdy  = sample_ready;
    end

    task automatic wait_pulses(input int n, input int budget);
        int k = 0;
        while (pulses < n && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        if (pulses < n) check("timeout_pulse", pulses, n);
    endtask

    task automatic wait_start(input int n, input int budget);
        int k = 0;
        while (starts < n && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        if (starts < n) check("timeout_start", starts, n);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    int p0;
    int s0;
    int t0;
    int acc;
    logic [11:0] w;

    initial begin
        // Reset values
        idle_cycles(4);
        check("rst_cs_n", adc_cs_n, 1'b1);
        check("rst_sclk", adc_sclk, 1'b0);
        check("rst_sample", sample, 32'h0);
        check("rst_ready", sample_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        idle_cycles(3);

`ifndef ADC_DISCARD_FIRST_EN
        // Single conversion from a one-edge enable
        adc_q.push_back(12'hA5C);
        p0 = pulses;
        enable = 1'b1;
        idle_cycles(1);
        enable = 1'b0;
        wait_pulses(p0 + 1, 200);
        check("t1_sample", sample, 32'h00000A5C);
        idle_cycles(150);
        check("t1_pulse_count", pulses - p0, 1);
        check("t1_busy_idle", busy, 1'b0);

        // Back-to-back conversions at the fixed interval
        adc_q.push_back(12'h001);
        adc_q.push_back(12'hFFF);
        p0 = pulses;
        enable = 1'b1;
        wait_pulses(p0 + 1, 200);
        check("t2_sample_a", sample, 32'h1);
        wait_pulses(p0 + 2, 200);
        enable = 1'b0;
        check("t2_gap", pulse_gap, SI);
        check("t2_sample_b", sample, 32'hFFF);
        idle_cycles(5);

        // Enable dropped mid-conversion
        adc_q.push_back(12'h800);
        p0 = pulses;
        s0 = starts;
        enable = 1'b1;
        wait_start(s0 + 1, 50);
        idle_cycles(20);
        enable = 1'b0;
        wait_pulses(p0 + 1, 200);
        check("t3_sample", sample, 32'h800);
        s0 = starts;
        idle_cycles(300);
        check("t3_no_restart", starts, s0);
        check("t3_pulse_count", pulses - p0, 1);
        check("t3_cs_idle", adc_cs_n, 1'b1);

        // Reset mid-conversion discards the partial result
        p0 = pulses;
        s0 = starts;
        enable = 1'b1;
        wait_start(s0 + 1, 50);
        idle_cycles(30);
        #2 rst = 1'b1;
        #1;
        check("t4_cs_n", adc_cs_n, 1'b1);
        check("t4_sclk", adc_sclk, 1'b0);
        check("t4_sample", sample, 32'h0);
        check("t4_busy", busy, 1'b0);
        enable = 1'b0;
        idle_cycles(3);
        rst = 1'b0;
        idle_cycles(3);
        check("t4_no_pulse", pulses, p0);
        w = 12'($urandom);
        adc_q.push_back(w);
        enable = 1'b1;
        idle_cycles(1);
        enable = 1'b0;
        wait_pulses(p0 + 1, 200);
        check("t4_clean_sample", sample, {20'd0, w});
        idle_cycles(60);

        // Ten samples into a downstream averager
        p0 = pulses;
        acc = 0;
        for (int i = 0; i < 10; i++) adc_q.push_back(12'h064);
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wait_pulses(p0 + i + 1, 200);
            acc += int'(sample);
        end
        enable = 1'b0;
        idle_cycles(300);
        check("t5_pulse_count", pulses - p0, 10);
        check("t5_avg", acc / 10, 32'h64);
`else
        // First conversion after idle is dropped
        adc_q.push_back(12'h111);
        adc_q.push_back(12'h222);
        p0 = pulses;
        s0 = starts;
        enable = 1'b1;
        wait_start(s0 + 1, 50);
        t0 = last_start;
        wait_pulses(p0 + 1, 300);
        enable = 1'b0;
        check("t6_sample", sample, 32'h222);
        check("t6_first_pulse_time", last_pulse - t0, SI + CONV_LEN);
        idle_cycles(200);
        check("t6_pulse_count", pulses - p0, 1);
`endif

        // Randomized stream: random ADC words, random start delay
        for (int r = 0; r < 3; r++) begin
            p0 = pulses;
            idle_cycles($urandom_range(1, 20));
            enable = 1'b1;
            wait_pulses(p0 + 6, 900);
            enable = 1'b0;
            idle_cycles(150);
            check("rand_sb_drained", exp_q.size(), 0);
            check("rand_pulse_count", pulses - p0, 6);
        end

        check("no_sclk_when_cs_high", sclk_idle_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
